// File: rtl/axis_dtu_route_stage_pkg.sv
// Shared lynx types: stage state, route word constants and the route struct.
// Imported by the DTU route stage and its skid buffer.
package lynxTypes;

    localparam int LYNX_PID_BITS  = 6;
    localparam int LYNX_DATA_BITS = 512;
    localparam int CEU_ROUTE_BITS = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } route_stage_t;

    typedef struct packed {
        logic                      en;
        logic [CEU_ROUTE_BITS-1:0] route;
    } ceu_route_t;

endpackage

// File: rtl/axis_dtu_route_stage_skid.sv
// axis_skid_buf_2: 2-entry buffer holding a beat plus its sideband word.
// Ports: push_i/data_i/side_i in, valid_o/ready_i/data_o/side_o out,
// pop_o = handshake, cnt_o/cnt_d_o = current and next occupancy.
import lynxTypes::*;

module axis_skid_buf_2 #(
    parameter int DATA_W = 32,
    parameter int SIDE_W = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [SIDE_W-1:0] side_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [SIDE_W-1:0] side_o,
    output logic              pop_o,
    output logic [1:0]        cnt_o,
    output logic [1:0]        cnt_d_o
);

    localparam int W = DATA_W + SIDE_W;

    logic [W-1:0] mem_q [2];
    logic         rd_q;
    logic         wr_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;

    always_comb begin
        valid_o = (cnt_q != 2'd0);
        pop_o   = valid_o & ready_i;
        {side_o, data_o} = mem_q[rd_q];
        cnt_d = cnt_q;
        if (push_i && !pop_o) begin
            cnt_d = cnt_q + 2'd1;
        end else if (!push_i && pop_o) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    assign cnt_o   = cnt_q;
    assign cnt_d_o = cnt_d;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= {side_i, data_i};
                wr_q        <= ~wr_q;
            end
            if (pop_o) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axis_dtu_route_stage.sv
// Per-region DTU ingress stage: tags each beat with a packet-stable route,
// drops packets of disabled regions, counts forwarded/dropped packets.
// Ports: route_wr/route_cfg/route_en_cfg shadow write; s_axis_* in,
// m_axis_* + m_tdest out; pkt_cnt, drop_cnt, busy status.
import lynxTypes::*;

module axis_dtu_route_stage #(
    parameter int DATA_BITS  = LYNX_DATA_BITS,
    parameter int PID_BITS   = LYNX_PID_BITS,
    parameter int ROUTE_BITS = CEU_ROUTE_BITS,
    parameter int CNT_BITS   = 32
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   route_wr,
    input  logic [ROUTE_BITS-1:0]  route_cfg,
    input  logic                   route_en_cfg,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [DATA_BITS-1:0]   s_axis_tdata,
    input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic [PID_BITS-1:0]    s_axis_tid,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic [PID_BITS-1:0]    m_axis_tid,
    output logic [ROUTE_BITS-1:0]  m_tdest,
    output logic [CNT_BITS-1:0]    pkt_cnt,
    output logic [CNT_BITS-1:0]    drop_cnt,
    output logic                   busy
);

    localparam int KEEP_BITS = DATA_BITS / 8;
    localparam int SIDE_W    = ROUTE_BITS + PID_BITS + KEEP_BITS + 1;

    route_stage_t          state_q, state_d;
    logic                  shadow_en_q;
    logic [ROUTE_BITS-1:0] shadow_route_q;
    logic [ROUTE_BITS-1:0] act_route_q, act_route_d;
    logic                  tready_q, tready_d;
    logic [CNT_BITS-1:0]   pkt_cnt_q;
    logic [CNT_BITS-1:0]   drop_cnt_q;

    logic                  acc;
    logic                  push;
    logic [ROUTE_BITS-1:0] push_route;
    logic                  drop_last;
    logic                  pkt_done;

    logic                  buf_valid;
    logic                  buf_pop;
    logic [1:0]            buf_cnt, buf_cnt_d;
    logic [SIDE_W-1:0]     side_in, side_out;
    logic [ROUTE_BITS-1:0] head_route;

    assign acc = s_axis_tvalid & tready_q;

    // The first beat of a packet uses the shadow as it stood before this
    // edge, so a same-cycle route_wr only affects later packets.
    always_comb begin
        state_d     = state_q;
        act_route_d = act_route_q;
        push        = 1'b0;
        push_route  = act_route_q;
        drop_last   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    act_route_d = shadow_route_q;
                    push_route  = shadow_route_q;
                    push        = shadow_en_q;
                    drop_last   = s_axis_tlast & ~shadow_en_q;
                    if (!s_axis_tlast) begin
                        state_d = shadow_en_q ? FWD : DROP;
                    end
                end
            end
            FWD: begin
                if (acc) begin
                    push = 1'b1;
                    if (s_axis_tlast) begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (acc && s_axis_tlast) begin
                    drop_last = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Registered ready: look at next-cycle occupancy, never at m_axis_tready.
        tready_d = (buf_cnt_d != 2'd2) || (state_d == DROP);
    end

    assign side_in = {push_route, s_axis_tid, s_axis_tkeep, s_axis_tlast};

    axis_skid_buf_2 #(
        .DATA_W (DATA_BITS),
        .SIDE_W (SIDE_W)
    ) u_buf (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push_i  (push),
        .data_i  (s_axis_tdata),
        .side_i  (side_in),
        .ready_i (m_axis_tready),
        .valid_o (buf_valid),
        .data_o  (m_axis_tdata),
        .side_o  (side_out),
        .pop_o   (buf_pop),
        .cnt_o   (buf_cnt),
        .cnt_d_o (buf_cnt_d)
    );

    assign {head_route, m_axis_tid, m_axis_tkeep, m_axis_tlast} = side_out;
    assign m_axis_tvalid = buf_valid;
    assign m_tdest       = buf_valid ? head_route : '0;
    assign pkt_done      = buf_pop & m_axis_tlast;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= IDLE;
            shadow_en_q    <= 1'b0;
            shadow_route_q <= '0;
            act_route_q    <= '0;
            tready_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_route_q <= act_route_d;
            tready_q    <= tready_d;
            if (route_wr) begin
                shadow_en_q    <= route_en_cfg;
                shadow_route_q <= route_cfg;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (pkt_done) begin
                pkt_cnt_q <= pkt_cnt_q + 1'b1;
            end
            if (drop_last) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign s_axis_tready = tready_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign drop_cnt      = drop_cnt_q;
    assign busy          = (state_q != IDLE) || (buf_cnt != 2'd0);

endmodule

// File: tb/tb_axis_dtu_route_stage.sv
// Directed bench for axis_dtu_route_stage with an output scoreboard.
// Ends with a single TB_RESULT summary line.
module tb_axis_dtu_route_stage;

    localparam int DB = 32;
    localparam int PB = 6;
    localparam int RB = 14;
    localparam int CB = 32;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          route_wr;
    logic [RB-1:0] route_cfg;
    logic          route_en_cfg;
    logic          s_tvalid;
    logic          s_tready;
    logic [DB-1:0] s_tdata;
    logic [3:0]    s_tkeep;
    logic          s_tlast;
    logic [PB-1:0] s_tid;
    logic          m_tvalid;
    logic          m_tready;
    logic [DB-1:0] m_tdata;
    logic [3:0]    m_tkeep;
    logic          m_tlast;
    logic [PB-1:0] m_tid;
    logic [RB-1:0] m_tdest;
    logic [CB-1:0] pkt_cnt;
    logic [CB-1:0] drop_cnt;
    logic          busy;

    always #5 aclk = ~aclk;

    axis_dtu_route_stage #(
        .DATA_BITS  (DB),
        .PID_BITS   (PB),
        .ROUTE_BITS (RB),
        .CNT_BITS   (CB)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .route_wr      (route_wr),
        .route_cfg     (route_cfg),
        .route_en_cfg  (route_en_cfg),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tid    (s_tid),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tid    (m_tid),
        .m_tdest       (m_tdest),
        .pkt_cnt       (pkt_cnt),
        .drop_cnt      (drop_cnt),
        .busy          (busy)
    );

    typedef struct packed {
        logic [DB-1:0] data;
        logic [3:0]    keep;
        logic [PB-1:0] tid;
        logic          last;
        logic [RB-1:0] dest;
        logic          lat;
        logic [31:0]   acc;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            n_push = 0;
    int            n_pop = 0;
    int            last_pop_cyc = 0;
    bit            mon_occ = 0;
    bit            sdone = 0;
    logic [CB-1:0] exp_pkt = '0;
    logic [CB-1:0] exp_drop = '0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pop, stall stability, occupancy bound.
    logic          pv, pr;
    logic [63:0]   pd;
    exp_t          e;
    always @(negedge aclk) begin
        if (!aresetn) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (pv && !pr) begin
                chk("hold_valid", m_tvalid, 1);
                chk("hold_payload",
                    {m_tdest, m_tid, m_tkeep, m_tlast, m_tdata}, pd);
            end
            if (mon_occ) chk("occupancy_le_2", (n_push - n_pop) <= 2, 1);
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", m_tdata, 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    chk("tdata", m_tdata, e.data);
                    chk("tkeep", m_tkeep, e.keep);
                    chk("tid", m_tid, e.tid);
                    chk("tlast", m_tlast, e.last);
                    chk("tdest", m_tdest, e.dest);
                    if (e.lat) chk("latency", cyc - int'(e.acc), 0);
                    if (e.last) exp_pkt = exp_pkt + 1'b1;
                    n_pop++;
                    last_pop_cyc = cyc;
                end
            end
            pv = m_tvalid;
            pr = m_tready;
            pd = {7'd0, m_tdest, m_tid, m_tkeep, m_tlast, m_tdata};
        end
    end

    task automatic wr_route(input logic [RB-1:0] r, input logic en);
        route_wr     = 1'b1;
        route_cfg    = r;
        route_en_cfg = en;
        @(posedge aclk); #1;
        route_wr = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [DB-1:0] base,
                            input logic fwd, input logic [RB-1:0] dest,
                            input logic lat, input int wr_at,
                            input logic [RB-1:0] wr_r, input logic wr_en);
        logic ok;
        int   to;
        exp_t x;
        for (int i = 0; i < n; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = base + DB'(i);
            s_tkeep  = 4'hF ^ i[3:0];
            s_tid    = base[PB-1:0] + PB'(i);
            s_tlast  = (i == n - 1);
            if (i == wr_at) begin
                route_wr     = 1'b1;
                route_cfg    = wr_r;
                route_en_cfg = wr_en;
            end
            ok = 1'b0;
            to = 0;
            while (!ok) begin
                @(negedge aclk);
                ok = s_tready;
                if (!fwd) chk("drop_tready", s_tready, 1);
                @(posedge aclk); #1;
                route_wr = 1'b0;
                if (!ok) begin
                    to++;
                    if (to > 100) begin
                        chk("send_timeout", 0, 1);
                        s_tvalid = 1'b0;
                        return;
                    end
                end
            end
            if (fwd) begin
                x.data = s_tdata;
                x.keep = s_tkeep;
                x.tid  = s_tid;
                x.last = s_tlast;
                x.dest = dest;
                x.lat  = lat;
                x.acc  = cyc;
                sb.push_back(x);
                n_push++;
            end else if (i == n - 1) begin
                exp_drop = exp_drop + 1'b1;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int to = 0;
        while ((sb.size() != 0 || busy) && to < 200) begin
            @(posedge aclk); #1;
            to++;
        end
        chk("drain", to < 200, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [3:0] pat;
        aresetn      = 1'b0;
        route_wr     = 1'b0;
        route_cfg    = '0;
        route_en_cfg = 1'b0;
        s_tvalid     = 1'b0;
        s_tdata      = '0;
        s_tkeep      = '0;
        s_tlast      = 1'b0;
        s_tid        = '0;
        m_tready     = 1'b1;
        pat          = 4'b1001;

        repeat (3) @(negedge aclk);
        chk("rst_tready", s_tready, 0);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdest", m_tdest, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_busy", busy, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        chk("tready_before_edge", s_tready, 0);
        @(posedge aclk); #1;
        chk("tready_after_release", s_tready, 1);

        // single packet
        wr_route(14'h0A3C, 1'b1);
        send_pkt(4, 32'h100, 1'b1, 14'h0A3C, 1'b1, -1, '0, 1'b0);
        drain();
        chk("t1_pkt_cnt", pkt_cnt, 1);
        chk("t1_pkt_model", pkt_cnt, exp_pkt);

        // mid-packet rewrite
        send_pkt(8, 32'h200, 1'b1, 14'h0A3C, 1'b0, 1, 14'h0111, 1'b1);
        send_pkt(2, 32'h300, 1'b1, 14'h0111, 1'b0, -1, '0, 1'b0);
        drain();
        chk("t2_pkt_cnt", pkt_cnt, exp_pkt);

        // disabled route
        wr_route(14'h0111, 1'b0);
        send_pkt(2, 32'h400, 1'b0, '0, 1'b0, -1, '0, 1'b0);
        send_pkt(1, 32'h410, 1'b0, '0, 1'b0, -1, '0, 1'b0);
        send_pkt(3, 32'h420, 1'b0, '0, 1'b0, -1, '0, 1'b0);
        drain();
        chk("t3_drop_cnt", drop_cnt, 3);
        chk("t3_pkt_cnt", pkt_cnt, exp_pkt);

        // backpressure
        wr_route(14'h0222, 1'b1);
        t0 = cyc;
        mon_occ = 1'b1;
        sdone = 1'b0;
        fork
            begin
                send_pkt(16, 32'h500, 1'b1, 14'h0222, 1'b0, -1, '0, 1'b0);
                sdone = 1'b1;
            end
            begin
                int k = 0;
                while (!sdone) begin
                    m_tready = pat[k % 4];
                    k++;
                    @(posedge aclk); #1;
                end
                m_tready = 1'b1;
            end
        join
        drain();
        mon_occ = 1'b0;
        chk("t4_min_time", (last_pop_cyc - t0) >= 18, 1);
        chk("t4_pkt_cnt", pkt_cnt, exp_pkt);
        chk("t4_all_beats", n_pop, n_push);

        // reset mid-packet with two entries buffered
        wr_route(14'h0333, 1'b1);
        drain();
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'h600;
        s_tkeep  = 4'hF;
        s_tid    = 6'd1;
        s_tlast  = 1'b0;
        @(posedge aclk); #1;
        s_tdata = 32'h601;
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("t5_full_tready", s_tready, 0);
        chk("t5_busy", busy, 1);
        chk("t5_tdest_held", m_tdest, 14'h0333);
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        #1;
        chk("t5_rst_tready", s_tready, 0);
        chk("t5_rst_tvalid", m_tvalid, 0);
        chk("t5_rst_tdest", m_tdest, 0);
        chk("t5_rst_pkt_cnt", pkt_cnt, 0);
        chk("t5_rst_drop_cnt", drop_cnt, 0);
        chk("t5_rst_busy", busy, 0);
        exp_pkt  = '0;
        exp_drop = '0;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        aresetn  = 1'b1;
        m_tready = 1'b1;
        @(posedge aclk); #1;
        send_pkt(2, 32'h700, 1'b0, '0, 1'b0, -1, '0, 1'b0);
        drain();
        chk("t5_drop_after_rst", drop_cnt, exp_drop);
        chk("t5_pkt_after_rst", pkt_cnt, 0);

        // counter wrap
        wr_route(14'h0444, 1'b1);
        force dut.pkt_cnt_q = 32'hFFFF_FFFF;
        @(posedge aclk); #1;
        release dut.pkt_cnt_q;
        exp_pkt = 32'hFFFF_FFFF;
        chk("t6_preload", pkt_cnt, 32'hFFFF_FFFF);
        send_pkt(1, 32'h800, 1'b1, 14'h0444, 1'b1, -1, '0, 1'b0);
        drain();
        chk("t6_wrap", pkt_cnt, 0);
        chk("t6_wrap_model", pkt_cnt, exp_pkt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
